// File: rtl/if_prefetch_queue_if.sv
// Handshake bundle for if_prefetch_queue: instruction-memory port, redirect, IF/ID output side.
// master = the prefetch queue, slave = memory/pipeline environment.
interface if_prefetch_queue_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned DEPTH       = 4
);
    logic                       imem_req;
    logic [ADDR_WIDTH-1:0]      imem_addr;
    logic                       imem_ready;
    logic [INSTR_WIDTH-1:0]     imem_rdata;
    logic                       redirect;
    logic [ADDR_WIDTH-1:0]      redirect_pc;
    logic                       out_valid;
    logic                       out_ready;
    logic [INSTR_WIDTH-1:0]     out_instr;
    logic [ADDR_WIDTH-1:0]      out_pc;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, count,
        input  imem_ready, imem_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, count,
        output imem_ready, imem_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue decoupling fetch from decode, with redirect flush.
// Optional same-cycle fetch-to-output bypass when PREFETCH_BYPASS_EN is defined.
module if_prefetch_queue #(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            INSTR_WIDTH = 32,
    parameter int unsigned            DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(32'h0000_0013)
) (
    input logic                clk,
    input logic                reset,
    if_prefetch_queue_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];

    logic empty, req, fetch_fire, push, pop;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    assign empty      = (count_q == '0);
    // Full queue stalls fetch even if a pop lands this cycle: no out_ready -> imem_req path.
    assign req        = !reset && !bus.redirect && (count_q < DEPTH_C);
    assign fetch_fire = req && bus.imem_ready;
    assign pop        = !empty && bus.out_ready && !bus.redirect;

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.count     = count_q;

`ifdef PREFETCH_BYPASS_EN
    logic bypass;
    // Fetch fire already excludes redirect, so redirect suppresses the bypass too.
    assign bypass = empty && fetch_fire;
    assign push   = fetch_fire && !(bypass && bus.out_ready);

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_instr = NOP_INSTR;
        bus.out_pc    = '0;
        if (!empty) begin
            bus.out_valid = 1'b1;
            bus.out_instr = instr_mem[rd_ptr_q];
            bus.out_pc    = pc_mem[rd_ptr_q];
        end else if (bypass) begin
            bus.out_valid = 1'b1;
            bus.out_instr = bus.imem_rdata;
            bus.out_pc    = fetch_pc_q;
        end
    end
`else
    assign push = fetch_fire;

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_instr = NOP_INSTR;
        bus.out_pc    = '0;
        if (!empty) begin
            bus.out_valid = 1'b1;
            bus.out_instr = instr_mem[rd_ptr_q];
            bus.out_pc    = pc_mem[rd_ptr_q];
        end
    end
`endif

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (fetch_fire) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            if (push)       wr_ptr_d   = wr_ptr_q + PW'(1);
            if (pop)        rd_ptr_d   = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
            instr_mem[wr_ptr_q] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed scenarios plus random traffic against a queue model.
module tb_if_prefetch_queue;
    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [AW-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [IW-1:0] NOP_INSTR = 32'h0000_0013;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    logic [AW-1:0] m_pc_q    [$];
    logic [IW-1:0] m_instr_q [$];
    logic [AW-1:0] m_fetch_pc;

    if_prefetch_queue_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) bus ();

    if_prefetch_queue #(
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW),
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC),
        .NOP_INSTR  (NOP_INSTR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".req"},   64'(bus.imem_req),  64'd0);
        check_eq({tag, ".addr"},  64'(bus.imem_addr), 64'(RESET_PC));
        check_eq({tag, ".valid"}, 64'(bus.out_valid), 64'd0);
        check_eq({tag, ".instr"}, 64'(bus.out_instr), 64'(NOP_INSTR));
        check_eq({tag, ".pc"},    64'(bus.out_pc),    64'd0);
        check_eq({tag, ".count"}, 64'(bus.count),     64'd0);
    endtask

    // Called at posedge+1: apply inputs, check combinational outputs mid-cycle, advance model.
    task automatic step(input logic rdr, input logic [AW-1:0] rpc, input logic rdy,
                        input logic ordy);
        logic          exp_req, fire, byp, exp_valid;
        logic [IW-1:0] exp_instr, rdata;
        logic [AW-1:0] exp_pc;
        int            n;
        rdata           = $urandom();
        bus.redirect    = rdr;
        bus.redirect_pc = rpc;
        bus.imem_ready  = rdy;
        bus.imem_rdata  = rdata;
        bus.out_ready   = ordy;
        #4;
        n       = m_pc_q.size();
        exp_req = !rdr && (n < DEPTH);
        fire    = exp_req && rdy;
        byp     = 1'b0;
`ifdef PREFETCH_BYPASS_EN
        byp = (n == 0) && fire;
`endif
        if (n > 0) begin
            exp_valid = 1'b1;
            exp_instr = m_instr_q[0];
            exp_pc    = m_pc_q[0];
        end else if (byp) begin
            exp_valid = 1'b1;
            exp_instr = rdata;
            exp_pc    = m_fetch_pc;
        end else begin
            exp_valid = 1'b0;
            exp_instr = NOP_INSTR;
            exp_pc    = '0;
        end
        check_eq("imem_req",  64'(bus.imem_req),  64'(exp_req));
        check_eq("imem_addr", 64'(bus.imem_addr), 64'(m_fetch_pc));
        check_eq("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        check_eq("out_instr", 64'(bus.out_instr), 64'(exp_instr));
        check_eq("out_pc",    64'(bus.out_pc),    64'(exp_pc));
        check_eq("count",     64'(bus.count),     64'(n));
        @(posedge clk);
        if (rdr) begin
            m_pc_q.delete();
            m_instr_q.delete();
            m_fetch_pc = rpc & ~32'h3;
        end else begin
            if (n > 0 && ordy) begin
                void'(m_pc_q.pop_front());
                void'(m_instr_q.pop_front());
            end
            if (fire) begin
                if (!(byp && ordy)) begin
                    m_pc_q.push_back(m_fetch_pc);
                    m_instr_q.push_back(rdata);
                end
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        #1;
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_ready  = 1'b0;
        bus.imem_rdata  = '0;
        bus.out_ready   = 1'b0;
        m_fetch_pc      = RESET_PC;
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill to full, then hold at 0x10.
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
        // One pop from full, then fetch 0x10.
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Steady stream from 0.
        step(1'b1, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b1);

        // Memory stall at 0x8.
        step(1'b1, 32'h0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Redirect with 3 queued entries and out_ready high.
        step(1'b1, 32'h0000_1003, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(15) == 0), $urandom(), ($urandom_range(3) != 0),
                 1'($urandom_range(1)));
        end

        // Asynchronous reset mid-stream with two entries queued.
        step(1'b1, 32'h0000_0200, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check_eq("pre_reset.count", 64'(bus.count), 64'd2);
        bus.imem_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        m_pc_q.delete();
        m_instr_q.delete();
        m_fetch_pc = RESET_PC;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(15) == 0), $urandom(), ($urandom_range(3) != 0),
                 1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
